fault_rst_ctrl: RTL and testbench
=================================

# fault_rst_ctrl

Reset sequencer driven by `fault_encoder`. It latches the registered fault record, optionally drains in-flight bus traffic, then asserts the SoC-wide reset `sys_rstn` for a fixed number of cycles. It keeps the cause, address and a fault count across that reset so boot firmware can read them. It also stretches power-on reset and serves software reset requests. It sits in the always-on reset domain next to `fault_encoder`, which itself is held in reset by `sys_rstn`.

## Interface
- `RST_CYCLES`, 16: cycles `sys_rstn` is held low per reset event; must be ≥ 2.
- `DRAIN_TIMEOUT`, 64: maximum DRAIN-state cycles; must be ≥ 1. Used only with `FEMTO_FAULT_DRAIN_EN`.
- `CNT_W`, 4: width of `fault_cnt`.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset (power-on).
- `fault` in 1: registered fault flag from `fault_encoder`.
- `fault_cause` in 8: `RST_FAULT_*` code, valid while `fault`=1.
- `fault_addr` in `XLEN`: faulting address/PC, valid while `fault`=1.
- `sw_rst_req` in 1: software reset request, single-cycle or level.
- `bus_idle` in 1: 1 when no ibus/dbus/pbus transaction is outstanding.
- `clr` in 1: clears the reset record.
- `sys_rstn` out 1: active-low reset to core, buses and peripherals; registered.
- `rst_src` out 2: 00 power-on, 01 fault, 10 software.
- `rst_cause` out 8: latched `fault_cause`; 0 unless `rst_src`=01.
- `rst_addr` out `XLEN`: latched `fault_addr`; 0 unless `rst_src`=01.
- `fault_cnt` out `CNT_W`: saturating count of fault resets.
- `busy` out 1: 1 in any state other than IDLE.

## Operation
- States: IDLE, DRAIN, ASSERT, RELEASE. Reset state is ASSERT with the cycle counter at 0.
- Reset values: `sys_rstn`=0, `busy`=1, `rst_src`=00, `rst_cause`=0, `rst_addr`=0, `fault_cnt`=0.
- **IDLE**
  - `fault`=1: latch `rst_src`=01, `rst_cause`, `rst_addr`; increment `fault_cnt`, saturating at all-ones. Go to DRAIN.
  - `sw_rst_req`=1 (and `fault`=0): `rst_src`=10, `rst_cause`=0, `rst_addr`=0, `fault_cnt` unchanged. Go to DRAIN.
  - `fault` takes priority over `sw_rst_req` in the same cycle.
  - `clr`=1 with neither request: `rst_src`=00, cause, addr and `fault_cnt` all go to 0. If `clr` coincides with a request, the request wins and `clr` is dropped.
- **DRAIN**: `sys_rstn` stays 1. Go to ASSERT when `bus_idle`=1 or when the drain counter reaches `DRAIN_TIMEOUT`-1, whichever comes first. Minimum DRAIN residency is 1 cycle.
- **ASSERT**: `sys_rstn`=0. The counter runs 0..`RST_CYCLES`-1, then the state moves to RELEASE.
- **RELEASE**: `sys_rstn`=1 for exactly 1 cycle, then IDLE. This absorbs stale `fault`/`sw_rst_req` values while `fault_encoder` leaves reset.
- `fault`, `sw_rst_req` and `clr` are ignored outside IDLE. The record is never overwritten mid-sequence.
- Counter width is `$clog2(max(RST_CYCLES, DRAIN_TIMEOUT))`. The same counter serves both states and is cleared on every state entry.

## Timing
- Fault latency: `fault` high in cycle N → record valid and `busy`=1 in N+1.
  - With drain and `bus_idle`=1: `sys_rstn` falls in N+2.
  - Without drain: `sys_rstn` falls in N+1.
- `sys_rstn` low for exactly `RST_CYCLES` consecutive cycles per event.
- Power-on: `sys_rstn`=0 asynchronously while `rstn`=0. After `rstn` deasserts, `sys_rstn` stays low for `RST_CYCLES` more edges, then 1 cycle in RELEASE, then IDLE.
- `rstn` asserted mid-sequence: all state and record contents return to reset values asynchronously. `rst_src` reads 00 afterwards.
- Drain timeout: with `bus_idle` stuck at 0, DRAIN lasts exactly `DRAIN_TIMEOUT` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FEMTO_FAULT_DRAIN_EN` defined: DRAIN state, drain counter and `bus_idle` are live, as described above.
- Not defined: DRAIN is removed and IDLE goes directly to ASSERT. `bus_idle` is unused and `DRAIN_TIMEOUT` is ignored. All other behaviour is identical.

## Test plan
- **Power-on:** release `rstn` → `sys_rstn`=0 for 16 cycles, 1 RELEASE cycle, then `busy`=0; `rst_src`=00, `fault_cnt`=0.
- **Fault reset:** in IDLE, pulse `fault` with `RST_FAULT_DBUS` and addr 32'h2000_0010, `bus_idle`=1 → `rst_src`=01, cause/addr latched, `fault_cnt`=1, `sys_rstn` low 16 cycles starting 2 cycles after the pulse (1 cycle without drain).
- **Drain:** fault with `bus_idle`=0 that goes to 1 after 5 cycles → `sys_rstn` falls in the cycle after `bus_idle` rises. With `bus_idle` held at 0 → falls after 64 DRAIN cycles.
- **Priority and ignored inputs:** `fault` and `sw_rst_req` in the same cycle → `rst_src`=01. A second `fault` during ASSERT → record unchanged, `fault_cnt` incremented only once.
- **Software reset and clear:** `sw_rst_req` → `rst_src`=10, `rst_addr`=0, `fault_cnt` unchanged. Then `clr` in IDLE → `rst_src`=00, `fault_cnt`=0. 20 fault resets with `CNT_W`=4 → `fault_cnt` saturates at 15.
- **Mid-sequence reset:** assert `rstn` during ASSERT → all outputs take reset values immediately, and power-on stretching restarts when `rstn` is released.

Source files
------------

// File: rtl/fault_rst_ctrl.sv
// fault_rst_ctrl: reset sequencer for fault, software and power-on resets.
// The fault record (source, cause, address, saturating fault count) survives
// the system reset it triggers so that boot firmware can read it back.
// Optional feature: define FEMTO_FAULT_DRAIN_EN to wait for bus_idle_i (bounded
// by DrainTimeout cycles) before sys_rstn_o is pulled low.
module fault_rst_ctrl #(
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned DrainTimeout = 64,
  parameter int unsigned CntW         = 4,
  parameter int unsigned Xlen         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fault_i,
  input  logic [7:0]      fault_cause_i,
  input  logic [Xlen-1:0] fault_addr_i,
  input  logic            sw_rst_req_i,
  input  logic            bus_idle_i,
  input  logic            clr_i,
  output logic            sys_rstn_o,
  output logic [1:0]      rst_src_o,
  output logic [7:0]      rst_cause_o,
  output logic [Xlen-1:0] rst_addr_o,
  output logic [CntW-1:0] fault_cnt_o,
  output logic            busy_o
);

  localparam int unsigned MaxCyc = (RstCycles > DrainTimeout) ? RstCycles : DrainTimeout;
  localparam int unsigned CW     = $clog2(MaxCyc);
  localparam logic [CW-1:0] RstLast = CW'(RstCycles - 1);

  localparam logic [1:0] SrcPor   = 2'b00;
  localparam logic [1:0] SrcFault = 2'b01;
  localparam logic [1:0] SrcSw    = 2'b10;

  typedef enum logic [1:0] {StIdle, StDrain, StAssert, StRelease} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      src_q, src_d;
  logic [7:0]      cause_q, cause_d;
  logic [Xlen-1:0] addr_q, addr_d;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic            sys_rstn_q, busy_q;

`ifdef FEMTO_FAULT_DRAIN_EN
  localparam logic [CW-1:0] DrainLast = CW'(DrainTimeout - 1);
  localparam state_e StFirst = StDrain;
`else
  localparam state_e StFirst = StAssert;
  logic unused_bus_idle;
  assign unused_bus_idle = bus_idle_i;
`endif

  // Next-state and shared cycle counter; counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fault_i || sw_rst_req_i) state_d = StFirst;
      end
      StDrain: begin
`ifdef FEMTO_FAULT_DRAIN_EN
        if (bus_idle_i || (cnt_q == DrainLast)) state_d = StAssert;
`else
        state_d = StAssert;
`endif
      end
      StAssert: begin
        if (cnt_q == RstLast) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StAssert;
    endcase

    if ((state_d != state_q) || (state_q == StIdle) || (state_q == StRelease)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Record update: only IDLE looks at requests; fault beats sw request beats clear.
  always_comb begin
    src_d   = src_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    if (state_q == StIdle) begin
      if (fault_i) begin
        src_d   = SrcFault;
        cause_d = fault_cause_i;
        addr_d  = fault_addr_i;
        fcnt_d  = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
      end else if (sw_rst_req_i) begin
        src_d   = SrcSw;
        cause_d = '0;
        addr_d  = '0;
      end else if (clr_i) begin
        src_d   = SrcPor;
        cause_d = '0;
        addr_d  = '0;
        fcnt_d  = '0;
      end
    end
  end

  // State, record and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAssert;
      cnt_q      <= '0;
      src_q      <= SrcPor;
      cause_q    <= '0;
      addr_q     <= '0;
      fcnt_q     <= '0;
      sys_rstn_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      cause_q    <= cause_d;
      addr_q     <= addr_d;
      fcnt_q     <= fcnt_d;
      sys_rstn_q <= (state_d != StAssert);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign sys_rstn_o  = sys_rstn_q;
  assign busy_o      = busy_q;
  assign rst_src_o   = src_q;
  assign rst_cause_o = cause_q;
  assign rst_addr_o  = addr_q;
  assign fault_cnt_o = fcnt_q;

endmodule

// File: tb/tb_fault_rst_ctrl.sv
// Self-checking bench for fault_rst_ctrl: directed scenarios plus randomized
// IDLE events, checked against an event-level model of the reset record and
// the expected drain / assert / release phase lengths.
module tb_fault_rst_ctrl;

  localparam int unsigned RstCycles    = 16;
  localparam int unsigned DrainTimeout = 64;
  localparam int unsigned CntW         = 4;
  localparam int unsigned Xlen         = 32;
  localparam int unsigned CntMax       = (1 << CntW) - 1;
  localparam logic [7:0]  FaultDbus    = 8'h05;

`ifdef FEMTO_FAULT_DRAIN_EN
  localparam bit HasDrain = 1'b1;
`else
  localparam bit HasDrain = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            fault;
  logic [7:0]      fault_cause;
  logic [Xlen-1:0] fault_addr;
  logic            sw_rst_req;
  logic            bus_idle;
  logic            clr;
  logic            sys_rstn;
  logic [1:0]      rst_src;
  logic [7:0]      rst_cause;
  logic [Xlen-1:0] rst_addr;
  logic [CntW-1:0] fault_cnt;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference record
  int unsigned m_src, m_cause, m_addr, m_cnt;

  fault_rst_ctrl #(
    .RstCycles   (RstCycles),
    .DrainTimeout(DrainTimeout),
    .CntW        (CntW),
    .Xlen        (Xlen)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fault_i      (fault),
    .fault_cause_i(fault_cause),
    .fault_addr_i (fault_addr),
    .sw_rst_req_i (sw_rst_req),
    .bus_idle_i   (bus_idle),
    .clr_i        (clr),
    .sys_rstn_o   (sys_rstn),
    .rst_src_o    (rst_src),
    .rst_cause_o  (rst_cause),
    .rst_addr_o   (rst_addr),
    .fault_cnt_o  (fault_cnt),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rec(input string tag);
    check_eq({tag, ".src"},   64'(rst_src),   64'(m_src));
    check_eq({tag, ".cause"}, 64'(rst_cause), 64'(m_cause));
    check_eq({tag, ".addr"},  64'(rst_addr),  64'(m_addr));
    check_eq({tag, ".cnt"},   64'(fault_cnt), 64'(m_cnt));
  endtask

  function automatic void model_reset();
    m_src = 0; m_cause = 0; m_addr = 0; m_cnt = 0;
  endfunction

  function automatic void model_idle(input bit f, input bit s, input bit c,
                                     input int unsigned cause, input int unsigned addr);
    if (f) begin
      m_src = 1; m_cause = cause; m_addr = addr;
      if (m_cnt < CntMax) m_cnt = m_cnt + 1;
    end else if (s) begin
      m_src = 2; m_cause = 0; m_addr = 0;
    end else if (c) begin
      model_reset();
    end
  endfunction

  // Called at a negedge with the DUT already out of IDLE. Walks the sequence,
  // feeding junk requests (must be ignored) and bus_idle rising after idle_delay
  // DRAIN cycles, then checks the length of each phase.
  task automatic run_seq(input string tag, input bit expect_drain, input int idle_delay);
    int  n_drain = 0;
    int  n_low   = 0;
    int  n_rel   = 0;
    int  guard   = 0;
    int  exp_drain;
    bit  done    = 1'b0;
    while (!done && guard < 400) begin
      if (!busy) done = 1'b1;
      else if (!sys_rstn) n_low++;
      else if (n_low == 0) n_drain++;
      else n_rel++;
      if (done) begin
        fault = 1'b0; sw_rst_req = 1'b0; clr = 1'b0;
      end else begin
        fault       = 1'($urandom_range(0, 1));
        sw_rst_req  = 1'($urandom_range(0, 1));
        clr         = 1'($urandom_range(0, 1));
        fault_cause = 8'($urandom);
        fault_addr  = $urandom;
        if (n_low == 0 && n_drain > 0) bus_idle = ((n_drain - 1) >= idle_delay);
        else bus_idle = 1'($urandom_range(0, 1));
        @(negedge clk);
        guard++;
      end
    end
    exp_drain = !expect_drain ? 0 :
                ((idle_delay + 1) < DrainTimeout) ? idle_delay + 1 : DrainTimeout;
    check_eq({tag, ".done"},  64'(done),    64'd1);
    check_eq({tag, ".drain"}, 64'(n_drain), 64'(exp_drain));
    check_eq({tag, ".low"},   64'(n_low),   64'(RstCycles));
    check_eq({tag, ".rel"},   64'(n_rel),   64'd1);
    check_eq({tag, ".rstn"},  64'(sys_rstn), 64'd1);
  endtask

  // At a negedge in IDLE: present one request combination for one cycle.
  task automatic idle_event(input string tag, input bit f, input bit s, input bit c,
                            input logic [7:0] cause, input logic [Xlen-1:0] addr,
                            input int idle_delay);
    fault = f; sw_rst_req = s; clr = c;
    fault_cause = cause; fault_addr = addr;
    bus_idle = 1'($urandom_range(0, 1));
    model_idle(f, s, c, cause, addr);
    @(negedge clk);
    fault = 1'b0; sw_rst_req = 1'b0; clr = 1'b0;
    check_rec({tag, ".rec0"});
    if (f || s) begin
      check_eq({tag, ".busy"}, 64'(busy), 64'd1);
      check_eq({tag, ".rstn0"}, 64'(sys_rstn), 64'(HasDrain));
      run_seq(tag, HasDrain, idle_delay);
      check_rec({tag, ".rec1"});
    end else begin
      check_eq({tag, ".idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic power_on_release(input string tag);
    rst_n = 1'b1;
    model_reset();
    run_seq(tag, 1'b0, 0);
    check_rec({tag, ".rec"});
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; fault = 1'b0; fault_cause = '0; fault_addr = '0;
    sw_rst_req = 1'b0; bus_idle = 1'b0; clr = 1'b0;
    model_reset();

    // Power-on
    repeat (3) @(negedge clk);
    check_eq("por.rstn", 64'(sys_rstn), 64'd0);
    check_eq("por.busy", 64'(busy), 64'd1);
    check_rec("por.held");
    power_on_release("por");

    // Fault reset with bus idle
    idle_event("fault", 1'b1, 1'b0, 1'b0, FaultDbus, 32'h2000_0010, 0);
    // Drain: bus idle after 5 cycles, then stuck busy
    idle_event("drain5", 1'b1, 1'b0, 1'b0, 8'h11, 32'h0000_1234, 5);
    idle_event("drain_to", 1'b1, 1'b0, 1'b0, 8'h12, 32'h0000_5678, 1000);
    // Priority: fault over sw request and clear
    idle_event("prio", 1'b1, 1'b1, 1'b1, 8'h21, 32'hdead_beef, 0);
    // Software reset, then clear
    idle_event("sw", 1'b0, 1'b1, 1'b0, 8'h33, 32'hcafe_f00d, 2);
    idle_event("clr", 1'b0, 1'b0, 1'b1, 8'h44, 32'h1111_2222, 0);
    // Saturation
    for (int i = 0; i < 20; i++) begin
      idle_event("sat", 1'b1, 1'b0, 1'b0, 8'($urandom), $urandom, $urandom_range(0, 3));
    end
    check_eq("sat.cnt", 64'(fault_cnt), 64'(CntMax));

    // Randomized IDLE events
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      idle_event("rnd", (k < 4), (k >= 3 && k < 7), (k >= 6),
                 8'($urandom), $urandom,
                 ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 10));
    end

    // Mid-sequence reset during ASSERT
    fault = 1'b1; fault_cause = 8'h77; fault_addr = 32'h3000_0004; bus_idle = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    guard = 0;
    while (sys_rstn && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("mid.in_assert", 64'(sys_rstn), 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid.rstn", 64'(sys_rstn), 64'd0);
    check_eq("mid.busy", 64'(busy), 64'd1);
    check_rec("mid.async");
    @(negedge clk);
    power_on_release("mid.por");
    idle_event("post", 1'b1, 1'b0, 1'b0, 8'h09, 32'h0000_0040, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
